// File: rtl/pjw_arbiter.sv
// rtl/pjw_arbiter.sv - round-robin arbiter sequencing N requesters onto one PJW hash engine
// Optional engine watchdog enabled by defining PJW_ARB_TIMEOUT_EN.
module pjw_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [N*32-1:0]   req_data,
  output logic [N-1:0]      req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic              eng_valid,
  output logic [31:0]       eng_data,
  input  logic              eng_ready,
  input  logic [31:0]       eng_result,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, RESP} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr, rr_ptr_nx, sel, rsp_id_nx;
  logic           found, grant, captured, timed_out;
  logic [N-1:0]   req_ready_nx;
  logic           eng_valid_nx, rsp_valid_nx, busy_nx;
  logic [31:0]    eng_data_nx, rsp_data_nx;
  logic [31:0]    words [N];

  if (IDW != $clog2(N) || N < 2 || N > 16 || TIMEOUT < 1) begin : g_bad_cfg
    $error("pjw_arbiter: invalid parameter set");
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_words
    assign words[gi] = req_data[32*gi +: 32];
  end

  // Search starts one past the last grant so the last winner has lowest priority.
  always_comb begin : p_select
    logic [IDW:0] cand;
    cand  = '0;
    sel   = '0;
    found = 1'b0;
    for (int off = 1; off <= N; off++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(off);
      if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDW-1:0];
      end
    end
  end

`ifdef PJW_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt;
`endif

  always_comb begin : p_next
    state_nx  = state;
    grant     = 1'b0;
    captured  = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE:      if (found && eng_ready) begin
                   grant    = 1'b1;
                   state_nx = ISSUE;
                 end
      ISSUE:     state_nx = WAIT_LOW;
      WAIT_LOW:  if (!eng_ready) state_nx = WAIT_HIGH;
      WAIT_HIGH: if (eng_ready) begin
                   captured = 1'b1;
                   state_nx = RESP;
                 end
      RESP:      if (rsp_valid && rsp_ready) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
`ifdef PJW_ARB_TIMEOUT_EN
    if ((state == WAIT_LOW || state == WAIT_HIGH) && !captured &&
        wd_cnt == WDW'(TIMEOUT - 1)) begin
      timed_out = 1'b1;
      state_nx  = RESP;
    end
`endif
  end

  always_comb begin : p_out
    req_ready_nx = '0;
    if (grant) req_ready_nx[sel] = 1'b1;
    eng_valid_nx = (state_nx == ISSUE);
    eng_data_nx  = grant ? words[sel] : eng_data;
    rsp_id_nx    = grant ? sel : rsp_id;
    rr_ptr_nx    = grant ? sel : rr_ptr;
    rsp_data_nx  = captured ? eng_result : (timed_out ? 32'h0 : rsp_data);
    rsp_valid_nx = (state_nx == RESP);
    busy_nx      = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin : p_state
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= IDW'(N - 1);
      req_ready <= '0;
      eng_valid <= 1'b0;
      eng_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_ptr_nx;
      req_ready <= req_ready_nx;
      eng_valid <= eng_valid_nx;
      eng_data  <= eng_data_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_id    <= rsp_id_nx;
      rsp_data  <= rsp_data_nx;
      busy      <= busy_nx;
    end
  end

`ifdef PJW_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin : p_watchdog
    if (rst) begin
      wd_cnt  <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (grant) wd_cnt <= '0;
      else if (state == WAIT_LOW || state == WAIT_HIGH) wd_cnt <= wd_cnt + WDW'(1);
      if (grant) rsp_err <= 1'b0;
      else if (timed_out) rsp_err <= 1'b1;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_pjw_arbiter.sv
// tb/tb_pjw_arbiter.sv - directed bench for pjw_arbiter with a stub hash engine
// Timeout steps run only when PJW_ARB_TIMEOUT_EN is defined.
module tb_pjw_arbiter;
  localparam int E = 5;

  logic         clk, rst;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_data;
  logic         rsp_valid, rsp_err, rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data, eng_data, eng_result;
  logic         eng_valid, eng_ready, busy;

  logic         eng_stuck, eng_pend;
  logic [31:0]  eng_word;
  int           eng_cnt;
  int           tests, fails, n, bad;

  pjw_arbiter #(.N(4), .IDW(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready),
    .eng_valid(eng_valid), .eng_data(eng_data), .eng_ready(eng_ready), .eng_result(eng_result),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] nib(input logic [31:0] d);
    return {16'h0, d[27:24], d[19:16], d[11:8], d[3:0]};
  endfunction

  // Stub engine: registered input, Ready low for E cycles, result packs the low nibble of each byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      eng_ready  <= 1'b1;
      eng_pend   <= 1'b0;
      eng_cnt    <= 0;
      eng_word   <= '0;
      eng_result <= '0;
    end else begin
      if (eng_valid && eng_ready) begin
        eng_pend <= 1'b1;
        eng_word <= eng_data;
      end
      if (eng_pend) begin
        eng_pend  <= 1'b0;
        eng_ready <= 1'b0;
        eng_cnt   <= E;
      end else if (!eng_ready && !eng_stuck) begin
        if (eng_cnt == 1) begin
          eng_ready  <= 1'b1;
          eng_result <= nib(eng_word);
        end
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (req_ready == 4'b0 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    if (req_ready == 4'b0) cnt = -1;
  endtask

  task automatic wait_rsp(output int cnt);
    cnt = 0;
    while (!rsp_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    if (!rsp_valid) cnt = -1;
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] id, input logic [31:0] data, input logic err);
    chk({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_id"}, {30'b0, rsp_id}, {30'b0, id});
    chk({tag, "_data"}, rsp_data, data);
    chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, err});
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0; eng_stuck = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {28'b0, req_ready}, 32'h0);
    chk("rst_eng_valid", {31'b0, eng_valid}, 32'h0);
    chk("rst_eng_data", eng_data, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_id", {30'b0, rsp_id}, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    rsp_ready = 1'b1;

    // single request from requester 2
    req_valid = 4'b0100; req_data[64 +: 32] = 32'h01020304;
    wait_ready(n);
    chk("single_grant", {28'b0, req_ready}, 32'h4);
    chk("single_eng_valid", {31'b0, eng_valid}, 32'h1);
    chk("single_eng_data", eng_data, 32'h01020304);
    chk("single_busy", {31'b0, busy}, 32'h1);
    req_valid = 4'b0;
    @(negedge clk);
    chk("single_pulse_once", {28'b0, req_ready}, 32'h0);
    chk("single_eng_valid_once", {31'b0, eng_valid}, 32'h0);
    wait_rsp(n);
    chk("single_latency", n + 1, E + 3);
    check_rsp("single", 2'd2, 32'h00001234, 1'b0);
    @(negedge clk);
    chk("single_done_valid", {31'b0, rsp_valid}, 32'h0);
    chk("single_done_busy", {31'b0, busy}, 32'h0);

    // round robin from reset pointer with all four continuously requesting
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) req_data[32*i +: 32] = 32'(i + 1);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ready(n);
      chk($sformatf("rr_grant%0d", i), {28'b0, req_ready}, 32'h1 << (i % 4));
      if (i == 4) req_valid = 4'b0;
      wait_rsp(n);
      check_rsp($sformatf("rr_rsp%0d", i), 2'(i % 4), 32'((i % 4) + 1), 1'b0);
    end
    @(negedge clk);

    // backpressure: hold RESP for 20 cycles while requester 3 waits
    rsp_ready = 1'b0;
    req_data[32 +: 32] = 32'h0A0B0C0D; req_data[96 +: 32] = 32'h11223344;
    req_valid = 4'b1010;
    wait_ready(n);
    chk("bp_grant", {28'b0, req_ready}, 32'h2);
    req_valid = 4'b1000;
    wait_rsp(n);
    check_rsp("bp_rsp", 2'd1, 32'h0000ABCD, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'h0000ABCD ||
          req_ready !== 4'b0 || busy !== 1'b1) bad++;
    end
    chk("bp_stable_cycles", bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'b0, rsp_valid}, 32'h0);
    wait_ready(n);
    chk("bp_next_grant_gap", n, 1);
    chk("bp_next_grant", {28'b0, req_ready}, 32'h8);
    req_valid = 4'b0;
    wait_rsp(n);
    check_rsp("bp_rsp2", 2'd3, 32'h00001234, 1'b0);
    @(negedge clk);

    // reset while waiting for the engine result
    req_data[64 +: 32] = 32'h55667788;
    req_valid = 4'b0100;
    wait_ready(n);
    chk("rstw_grant", {28'b0, req_ready}, 32'h4);
    req_valid = 4'b0;
    repeat (4) @(negedge clk);
    chk("rstw_busy_before", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_busy", {31'b0, busy}, 32'h0);
    chk("rstw_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rstw_rsp_id", {30'b0, rsp_id}, 32'h0);
    chk("rstw_rsp_data", rsp_data, 32'h0);
    chk("rstw_eng_data", eng_data, 32'h0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("rstw_quiet", bad, 0);
    req_data[0 +: 32] = 32'h01000000; req_data[96 +: 32] = 32'h00000009;
    req_valid = 4'b1001;
    wait_ready(n);
    chk("rstw_ptr_grant", {28'b0, req_ready}, 32'h1);
    req_valid = 4'b0;
    wait_rsp(n);
    check_rsp("rstw_rsp", 2'd0, 32'h00001000, 1'b0);
    @(negedge clk);

    // back-to-back words from requester 1
    req_data[32 +: 32] = 32'h00000001;
    req_valid = 4'b0010;
    wait_ready(n);
    chk("b2b_grant1", {28'b0, req_ready}, 32'h2);
    req_data[32 +: 32] = 32'h00000002;
    wait_rsp(n);
    check_rsp("b2b_rsp1", 2'd1, 32'h1, 1'b0);
    wait_ready(n);
    chk("b2b_gap", n, 2);
    chk("b2b_grant2", {28'b0, req_ready}, 32'h2);
    req_valid = 4'b0;
    wait_rsp(n);
    check_rsp("b2b_rsp2", 2'd1, 32'h2, 1'b0);
    @(negedge clk);

`ifdef PJW_ARB_TIMEOUT_EN
    // engine never raises Ready again: watchdog must answer with an error
    eng_stuck = 1'b1;
    req_data[64 +: 32] = 32'h01020304;
    req_valid = 4'b0100;
    wait_ready(n);
    chk("to_grant", {28'b0, req_ready}, 32'h4);
    req_valid = 4'b0;
    wait_rsp(n);
    chk("to_latency", n, 9);
    check_rsp("to_rsp", 2'd2, 32'h0, 1'b1);
    @(negedge clk);
    eng_stuck = 1'b0;
    req_data[96 +: 32] = 32'h00000005;
    req_valid = 4'b1000;
    wait_ready(n);
    chk("to_next_grant", {28'b0, req_ready}, 32'h8);
    req_valid = 4'b0;
    wait_rsp(n);
    check_rsp("to_next_rsp", 2'd3, 32'h5, 1'b0);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
